// File: rtl/rf_pkg.sv
// Shared types and defaults for the multiport register file with clear sequencer.
// Optional build macro: RF_BYPASS_EN (write-through forwarding on the read ports).
package rf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } clr_state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int NUM_RD_DEF = 3;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: on request sweeps one register per cycle to zero, then pulses done.
// Latency: DEPTH busy cycles plus one DONE cycle; writes arriving while busy are dropped and flagged.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    input  logic              wr_req_i,
    output logic              clr_stb_o,
    output logic [ADDR_W-1:0] clr_idx_o,
    output logic              wr_gate_o,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              wr_dropped_o
);

    localparam int                DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;
    logic              drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= busy_q && wr_req_i;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // busy_q mirrors the SWEEP state, so it doubles as the clear strobe
    assign clr_stb_o    = busy_q;
    assign clr_idx_o    = idx_q;
    assign wr_gate_o    = ~busy_q;
    assign clr_busy_o   = busy_q;
    assign clr_done_o   = done_q;
    assign wr_dropped_o = drop_q;

endmodule

// File: rtl/rf_multiport_clr.sv
// Register file with NUM_RD combinational read ports, one write port and a hardware clear sweep.
// Optional build macro: RF_BYPASS_EN forwards an accepted write to matching read ports in the same cycle.
module rf_multiport_clr
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_dis,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     wr_dropped
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              clr_stb;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_gate;
    logic              wr_en;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk          (clk),
        .rst          (rst),
        .clr_req_i    (clr_req),
        .wr_req_i     (~wr_dis),
        .clr_stb_o    (clr_stb),
        .clr_idx_o    (clr_idx),
        .wr_gate_o    (wr_gate),
        .clr_busy_o   (clr_busy),
        .clr_done_o   (clr_done),
        .wr_dropped_o (wr_dropped)
    );

    assign wr_en = ~wr_dis & wr_gate;

    // The clear strobe and an accepted write are mutually exclusive by construction
    always_comb begin
        regs_d = regs_q;
        if (clr_stb) begin
            regs_d[clr_idx] = '0;
        end else if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        assign sel = rd_sel[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
        assign rd_data[k*DATA_W +: DATA_W] = (wr_en && (sel == wr_addr)) ? wr_data : regs_q[sel];
`else
        assign rd_data[k*DATA_W +: DATA_W] = regs_q[sel];
`endif
    end

endmodule
